// File: rtl/obj_move_ctrl_pkg.sv
// Shared definitions for the player-square movement loop: direction and
// state encodings, screen limits, and the pre-move bound check.
package obj_move_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  // Screen size in pixels; the collision checkers use the same limits.
  localparam int unsigned X_LIM = 640;
  localparam int unsigned Y_LIM = 480;

  // True when a one-pixel move in dir keeps the square fully on screen.
  // Sums are formed in 11 bits so position + side cannot wrap.
  function automatic logic move_in_bounds(
    input dir_t       dir,
    input logic [9:0] x,
    input logic [8:0] y,
    input logic [6:0] side
  );
    logic [10:0] x_far;
    logic [10:0] y_far;
    logic        ok;
    x_far = {1'b0, x} + {4'b0, side};
    y_far = {2'b0, y} + {4'b0, side};
    ok    = 1'b0;
    case (dir)
      DIR_UP:    ok = (y != 9'd0);
      DIR_DOWN:  ok = (y_far < 11'(Y_LIM));
      DIR_LEFT:  ok = (x != 10'd0);
      DIR_RIGHT: ok = (x_far < 11'(X_LIM));
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/obj_move_ctrl_tick_gen.sv
// Free-running step divider: one-cycle tick every TICK_DIV clocks.
module move_tick_gen #(
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic VGA_clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and wrap; runs regardless of the movement FSM.
  always_ff @(posedge VGA_clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Decoded from the counter register only, so it is glitch-free and
  // high exactly on the wrap cycle.
  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/obj_move_ctrl.sv
// Player-square movement controller. Moves one pixel per step tick in the
// key direction, waits for the collision checkers to re-evaluate the new
// position, and reverts the move if the matching flag comes back set.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a tick with a key held and room to move
//   ST_STEP   | moved position is on the outputs; arm the settle counter
//   ST_SETTLE | give the negedge-registered checkers time to update
//   ST_CHECK  | sample the flag for the latched direction, revert if set
//
// SETTLE must be at least 2: the checkers register on negedge, so one
// cycle is not enough for a fresh flag to reach this block.
module obj_move_ctrl
  import obj_move_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned X_START  = 110,
  parameter int unsigned Y_START  = 130
) (
  input  logic       VGA_clk,
  input  logic       reset_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic [6:0] tamanho,
  input  logic       colisao_min_y,
  input  logic       colisao_max_y,
  input  logic       colisao_min_x,
  input  logic       colisao_max_x,
  output logic [9:0] xPos,
  output logic [8:0] yPos,
  output logic       busy,
  output logic       bump,
  output logic [7:0] bump_count
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  logic          tick;

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [9:0]    px_q, px_d;
  logic [8:0]    py_q, py_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          busy_q, busy_d;
  logic          bump_q, bump_d;
  logic [7:0]    bcnt_q, bcnt_d;

  logic          key_any;
  dir_t          dir_sel;
  logic          move_ok;
  logic          flag_hit;

  move_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .VGA_clk (VGA_clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Fixed key priority: up > down > left > right.
  always_comb begin
    key_any = key_up | key_down | key_left | key_right;
    dir_sel = DIR_RIGHT;
    if (key_up) begin
      dir_sel = DIR_UP;
    end else if (key_down) begin
      dir_sel = DIR_DOWN;
    end else if (key_left) begin
      dir_sel = DIR_LEFT;
    end
    move_ok = move_in_bounds(dir_sel, x_q, y_q, tamanho);
  end

  // Only the flag facing the latched direction can cause a revert.
  always_comb begin
    flag_hit = 1'b0;
    case (dir_q)
      DIR_UP:    flag_hit = colisao_min_y;
      DIR_DOWN:  flag_hit = colisao_max_y;
      DIR_LEFT:  flag_hit = colisao_min_x;
      DIR_RIGHT: flag_hit = colisao_max_x;
      default:   flag_hit = 1'b0;
    endcase
  end

  // Next-state and datapath updates; every target defaults to hold.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    x_d      = x_q;
    y_d      = y_q;
    px_d     = px_q;
    py_d     = py_q;
    settle_d = settle_q;
    bump_d   = 1'b0;
    bcnt_d   = bcnt_q;

    case (state_q)
      ST_IDLE: begin
        // The move is registered on the tick edge itself, so the new
        // position is already on xPos/yPos throughout ST_STEP. Ticks in
        // any other state are simply not looked at.
        if (tick && key_any && move_ok) begin
          dir_d   = dir_sel;
          px_d    = x_q;
          py_d    = y_q;
          state_d = ST_STEP;
          case (dir_sel)
            DIR_UP:    y_d = y_q - 9'd1;
            DIR_DOWN:  y_d = y_q + 9'd1;
            DIR_LEFT:  x_d = x_q - 10'd1;
            DIR_RIGHT: x_d = x_q + 10'd1;
            default:   x_d = x_q;
          endcase
        end
      end

      ST_STEP: begin
        settle_d = SETTLE_LOAD;
        state_d  = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      ST_CHECK: begin
        if (flag_hit) begin
          x_d    = px_q;
          y_d    = py_q;
          bump_d = 1'b1;
          if (bcnt_q != 8'hFF) begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any in-flight move.
  always_ff @(posedge VGA_clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_UP;
      x_q      <= 10'(X_START);
      y_q      <= 9'(Y_START);
      px_q     <= 10'(X_START);
      py_q     <= 9'(Y_START);
      settle_q <= '0;
      busy_q   <= 1'b0;
      bump_q   <= 1'b0;
      bcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      px_q     <= px_d;
      py_q     <= py_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      bump_q   <= bump_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign xPos       = x_q;
  assign yPos       = y_q;
  assign busy       = busy_q;
  assign bump       = bump_q;
  assign bump_count = bcnt_q;

endmodule

// File: tb/tb_obj_move_ctrl.sv
// Bench for obj_move_ctrl: directed phases plus randomized keys, side and
// collision walls, checked every cycle against a step-schedule model.
module tb_obj_move_ctrl;

  localparam int TD = 4;
  localparam int ST = 2;
  localparam int XS = 110;
  localparam int YS = 130;

  logic       VGA_clk = 1'b0;
  logic       reset_n;
  logic       key_up, key_down, key_left, key_right;
  logic [6:0] tamanho;
  logic       colisao_min_y, colisao_max_y, colisao_min_x, colisao_max_x;
  logic [9:0] xPos;
  logic [8:0] yPos;
  logic       busy, bump;
  logic [7:0] bump_count;

  always #5 VGA_clk = ~VGA_clk;

  obj_move_ctrl #(
    .TICK_DIV (TD),
    .SETTLE   (ST),
    .X_START  (XS),
    .Y_START  (YS)
  ) dut (
    .VGA_clk       (VGA_clk),
    .reset_n       (reset_n),
    .key_up        (key_up),
    .key_down      (key_down),
    .key_left      (key_left),
    .key_right     (key_right),
    .tamanho       (tamanho),
    .colisao_min_y (colisao_min_y),
    .colisao_max_y (colisao_max_y),
    .colisao_min_x (colisao_min_x),
    .colisao_max_x (colisao_max_x),
    .xPos          (xPos),
    .yPos          (yPos),
    .busy          (busy),
    .bump          (bump),
    .bump_count    (bump_count)
  );

  // Reference: position, bump counter, and a countdown of edges left
  // until the pending move is judged (0 = no move in flight).
  int m_x, m_y, m_bc, m_left, m_ec, m_dir, m_px, m_py;
  bit m_bump;

  int fmode;
  int wl, wr, wt, wb;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit can_move(input int d, input int x, input int y, input int t);
    case (d)
      0: return y > 0;
      1: return (y + t) < 480;
      2: return x > 0;
      default: return (x + t) < 640;
    endcase
  endfunction

  // Applied at each rising edge using the inputs the DUT sees there.
  task automatic model_edge();
    bit tk, f;
    int d;
    if (!reset_n) begin
      m_x = XS; m_y = YS; m_bc = 0; m_left = 0; m_ec = 0; m_bump = 0;
      return;
    end
    tk = ((m_ec % TD) == TD - 1);
    m_ec++;
    m_bump = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        case (m_dir)
          0: f = colisao_min_y;
          1: f = colisao_max_y;
          2: f = colisao_min_x;
          default: f = colisao_max_x;
        endcase
        if (f) begin
          m_x = m_px; m_y = m_py; m_bump = 1;
          if (m_bc < 255) m_bc++;
        end
      end
    end else if (tk) begin
      d = key_up ? 0 : key_down ? 1 : key_left ? 2 : key_right ? 3 : -1;
      if (d >= 0 && can_move(d, m_x, m_y, int'(tamanho))) begin
        m_px = m_x; m_py = m_y; m_dir = d;
        case (d)
          0: m_y--;
          1: m_y++;
          2: m_x--;
          default: m_x++;
        endcase
        m_left = ST + 2;
      end
    end
  endtask

  // Emulates negedge-registered collision checkers from the model position.
  task automatic update_flags();
    int t;
    t = int'(tamanho);
    colisao_min_y = 0; colisao_max_y = 0; colisao_min_x = 0; colisao_max_x = 0;
    case (fmode)
      1: colisao_min_y = (m_y < 110);
      2: colisao_min_x = 1;
      3: colisao_min_y = 1;
      4: begin
        colisao_min_x = (m_x < wl) || ($urandom_range(0, 15) == 0);
        colisao_max_x = (m_x + t > wr) || ($urandom_range(0, 15) == 0);
        colisao_min_y = (m_y < wt) || ($urandom_range(0, 15) == 0);
        colisao_max_y = (m_y + t > wb) || ($urandom_range(0, 15) == 0);
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    @(posedge VGA_clk);
    model_edge();
    @(negedge VGA_clk);
    check_val("xPos", int'(xPos), m_x);
    check_val("yPos", int'(yPos), m_y);
    check_val("busy", int'(busy), (m_left > 0) ? 1 : 0);
    check_val("bump", int'(bump), int'(m_bump));
    check_val("bump_count", int'(bump_count), m_bc);
    update_flags();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_keys(input logic u, input logic d, input logic l, input logic r);
    key_up = u; key_down = d; key_left = l; key_right = r;
  endtask

  task automatic do_reset(input int n);
    reset_n = 0;
    run(n);
    reset_n = 1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && m_left != 0; i++) cycle();
    check_val(tag, m_left, 0);
  endtask

  initial begin
    m_x = XS; m_y = YS; m_bc = 0; m_left = 0; m_ec = 0; m_dir = 0;
    m_px = XS; m_py = YS; m_bump = 0;
    fmode = 0; wl = 0; wr = 639; wt = 0; wb = 479;
    reset_n = 0;
    set_keys(1, 1, 1, 1);
    tamanho = 7'd10;
    colisao_min_y = 0; colisao_max_y = 0; colisao_min_x = 0; colisao_max_x = 0;

    // Reset with every key held.
    @(negedge VGA_clk);
    run(3);
    check_val("rst_x", int'(xPos), 110);
    check_val("rst_y", int'(yPos), 130);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_bump_count", int'(bump_count), 0);
    reset_n = 1;

    // Free move right; half the ticks land while busy and are dropped.
    set_keys(0, 0, 0, 1);
    run(3);
    check_val("no_move_before_tick", int'(xPos), 110);
    run(40);

    // Blocked upward walk: wall at y<110.
    do_reset(1);
    set_keys(1, 0, 0, 0);
    fmode = 1;
    run(400);
    wait_idle("blocked_idle");
    check_val("blocked_y", int'(yPos), 110);

    // Up beats left; left flag set must not revert the up move.
    do_reset(1);
    set_keys(1, 0, 1, 0);
    fmode = 2;
    run(60);
    wait_idle("prio_idle");
    check_val("prio_x", int'(xPos), 110);
    check_val("prio_bump_count", int'(bump_count), 0);

    // Right screen edge with a 127-pixel square: stops at 513.
    do_reset(1);
    fmode = 0;
    tamanho = 7'd127;
    set_keys(0, 0, 0, 1);
    run(3400);
    wait_idle("right_idle");
    check_val("right_edge_x", int'(xPos), 513);

    // Top screen edge.
    tamanho = 7'd10;
    set_keys(1, 0, 0, 0);
    run(1150);
    wait_idle("top_idle");
    check_val("top_edge_y", int'(yPos), 0);
    check_val("edge_bump_count", int'(bump_count), 0);

    // Constant up collision: counter saturates.
    do_reset(1);
    fmode = 3;
    run(2500);
    check_val("sat_bump_count", int'(bump_count), 255);

    // Reset during settle.
    do_reset(1);
    fmode = 0;
    set_keys(0, 0, 0, 1);
    for (int i = 0; i < 40 && m_left != 3; i++) cycle();
    check_val("reach_settle", m_left, 3);
    reset_n = 0;
    cycle();
    check_val("midrst_x", int'(xPos), 110);
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_bump", int'(bump), 0);
    reset_n = 1;

    // Random keys, square size, walls and flag noise, occasional reset.
    fmode = 4;
    wl = $urandom_range(0, 150);
    wr = $urandom_range(300, 639);
    wt = $urandom_range(0, 120);
    wb = $urandom_range(250, 479);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        logic [3:0] k;
        k = 4'($urandom_range(0, 15));
        set_keys(k[3], k[2], k[1], k[0]);
        tamanho = 7'($urandom_range(1, 127));
      end
      reset_n = ($urandom_range(0, 399) != 0);
      cycle();
    end
    reset_n = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/obj_move_ctrl.md
Name: obj_move_ctrl

Overview:
- Movement controller for the player square. It consumes the four registered collision flags: min_y (up), max_y (down), min_x (left), max_x (right).
- It drives xPos/yPos for the renderer and for the collision checkers.
- Each step-tick it applies a one-pixel move in the key direction and waits for the checkers to re-evaluate. If the flag for that direction asserts, it reverts the move.
- It is the other end of the collision interface: the checkers produce flags, and this block reacts to them and closes the position loop.

Parameters:
- TICK_DIV, 250000, VGA_clk cycles per movement step (100 Hz at 25 MHz).
- SETTLE, 2, cycles to wait after a move before sampling flags; must be >=2 because checkers register on negedge.
- X_START, 110, reset x position (top-left of square).
- Y_START, 130, reset y position.
- X_LIM, 640, screen width in pixels.
- Y_LIM, 480, screen height in pixels.

Ports:
- VGA_clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous active-low reset.
- key_up  in  1  debounced level, active-high.
- key_down  in  1  debounced level, active-high.
- key_left  in  1  debounced level, active-high.
- key_right  in  1  debounced level, active-high.
- tamanho  in  7  square side in pixels.
- colisao_min_y  in  1  up-collision flag, registered upstream.
- colisao_max_y  in  1  down-collision flag.
- colisao_min_x  in  1  left-collision flag.
- colisao_max_x  in  1  right-collision flag.
- xPos  out  10  current x.
- yPos  out  9  current y.
- busy  out  1  high from STEP through CHECK.
- bump  out  1  one-cycle pulse when a move is reverted.
- bump_count  out  8  saturating count of reverted moves.

Behaviour:
- Reset (reset_n=0 at posedge):
  - xPos=X_START, yPos=Y_START, state=IDLE.
  - Tick counter=0, busy=0, bump=0, bump_count=0.
  - Reset wins over every other event, including mid-step; any in-flight move is discarded.
- Tick counter:
  - Counts 0..TICK_DIV-1, then wraps; tick=1 for one cycle at wrap.
  - Free-running, independent of state.
- Direction select: on tick, sampled in IDLE only; fixed priority up > down > left > right; exactly one direction per step.
- States:
  - IDLE: on tick with any key, evaluate the bound check.
    - Check fails: stay in IDLE, no move, no bump.
    - Check passes: latch dir and prev xPos/yPos, go to STEP.
    - Bounds, in 11-bit arithmetic: up needs yPos>0; down needs yPos+tamanho<Y_LIM; left needs xPos>0; right needs xPos+tamanho<X_LIM.
  - STEP (1 cycle): apply the ±1 move to xPos/yPos, clear the settle counter, go to SETTLE.
  - SETTLE: count SETTLE cycles, then go to CHECK. Flags are ignored here.
  - CHECK (1 cycle): sample the flag matching the latched dir.
    - Flag=1: restore prev position, bump=1, bump_count+=1 (saturates at 255).
    - Then go to IDLE.
- A tick arriving while busy is dropped, not queued.
- Flags for other directions never affect the result.
- Keys released mid-step: the step completes normally.
- busy=1 in STEP, SETTLE and CHECK.
- Move latency: tick to new position visible = 1 cycle. Tick to revert = SETTLE+2 cycles.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package: the 2-bit direction encoding (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3), the state encoding, X_LIM and Y_LIM.
- The collision checkers also import X_LIM/Y_LIM from the package.
- One natural sub-module: move_tick_gen, the TICK_DIV divider producing the 1-cycle tick, with the same clock and reset.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with keys active -> xPos=110, yPos=130, bump_count=0, busy=0. After release, the first move happens only on a tick.
- Free move: key_right held, flags=0, TICK_DIV=4 for sim -> xPos goes 110, 111, 112 on successive ticks; yPos stays 130; busy pulses SETTLE+2 cycles per step.
- Blocked move: key_up held; model drives colisao_min_y=1 when yPos<110 -> position steps to 109, returns to 110 at CHECK; bump pulses once per tick; bump_count increments each step.
- Priority and wrong-direction flag: key_up and key_left both held, colisao_min_x=1 -> up move taken (yPos-1), no revert, bump stays 0.
- Screen bounds: set xPos to 630 via X_START=630, tamanho=10, key_right held -> xPos stays 630, state stays IDLE, bump never asserts. Repeat the same edge check at yPos=0 with key_up.
- Reset mid-operation: assert reset_n=0 during SETTLE -> next cycle position = (X_START, Y_START), busy=0, no bump. Also hold key_up with constant collision for 300 steps -> bump_count saturates at 255.
